chord_voice_scheduler: RTL and testbench

Sequences note/duration entries from the song reader onto the three voices of the chord player. It owns each voice's remaining-duration count, decrements the counts on beat, and frees voices when they expire. Single notes go to the first free voice. A three-note chord group waits until all voices are free, then loads voices 1, 2 and 3 in order. Outputs are the per-voice note and load strobes that drive the note players.

---
 rtl/chord_voice_scheduler.sv | 163 ++++++++++++++++
 tb/tb_chord_voice_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/chord_voice_scheduler.sv
// Chord voice scheduler: places song-reader note/duration entries onto three
// voices. Each voice keeps a remaining-beat count that decrements on beat.
// Single notes go to the first free voice, checked from voice 3 down to voice 1.
// A chord group waits until all voices are idle, then loads voices 1..3 in order.

// Per-voice slot: holds the note and the remaining duration.
module chord_voice_slot #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_i,
  input  logic              load_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [DUR_W-1:0]  dur_i,
  output logic [NOTE_W-1:0] note_o,
  output logic              active_o
);
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_q;

  // A load takes priority over the beat decrement, so a coincident load
  // keeps the full duration. A count of zero stays at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      note_q <= '0;
      dur_q  <= '0;
    end else if (load_i) begin
      note_q <= note_i;
      dur_q  <= dur_i;
    end else if (dec_i && dur_q != '0) begin
      dur_q  <= dur_q - 1'b1;
    end
  end

  assign active_o = (dur_q != '0);
  assign note_o   = active_o ? note_q : '0;
endmodule

module chord_voice_scheduler #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NOTE_W-1:0] in_note,
  input  logic [DUR_W-1:0]  in_duration,
  input  logic              in_chord,
  output logic [NOTE_W-1:0] note1,
  output logic [NOTE_W-1:0] note2,
  output logic [NOTE_W-1:0] note3,
  output logic [2:0]        voice_active,
  output logic [2:0]        voice_load,
  output logic              chord_busy,
  output logic              all_idle
);
  localparam int NUM_VOICES = 3;

  typedef enum logic [1:0] {S_RUN, S_CHORD_WAIT, S_CHORD_LOAD} state_t;

  state_t                            state_q, state_d;
  logic [1:0]                        idx_q, idx_d;
  logic [NUM_VOICES-1:0]             load_q, load_d;
  logic [NUM_VOICES-1:0]             sel_vec;
  logic [NUM_VOICES-1:0]             free;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_w;
  logic                              rdy_c;
  logic                              accept;
  logic                              dec;

  assign dec = beat & play;

  // One slot per voice; bit v-1 of each vector belongs to voice v.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    chord_voice_slot #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .dec_i    (dec),
      .load_i   (load_d[v]),
      .note_i   (in_note),
      .dur_i    (in_duration),
      .note_o   (note_w[v]),
      .active_o (voice_active[v])
    );
  end

  // Free test uses registered counts, so a voice expiring on this beat
  // only becomes available on the following cycle.
  assign free   = ~voice_active;
  assign accept = in_valid & in_ready;

  // Next-state, ready and voice selection for the scheduler FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rdy_c   = 1'b0;
    sel_vec = '0;
    case (state_q)
      S_RUN: begin
        if (in_valid && in_chord) begin
          if (play) state_d = S_CHORD_WAIT;
        end else begin
          rdy_c = play & (|free);
          if (in_valid && rdy_c) begin
            if (free[2])      sel_vec = 3'b100;
            else if (free[1]) sel_vec = 3'b010;
            else              sel_vec = 3'b001;
          end
        end
      end
      S_CHORD_WAIT: begin
        if (play && (&free)) begin
          state_d = S_CHORD_LOAD;
          idx_d   = 2'd0;
        end
      end
      S_CHORD_LOAD: begin
        rdy_c = play;
        if (in_valid && play) begin
          sel_vec = 3'b001 << idx_q;
          if (idx_q == 2'd2) begin
            state_d = S_RUN;
            idx_d   = 2'd0;
          end else begin
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_RUN;
        idx_d   = 2'd0;
      end
    endcase
    // Zero-duration entries are consumed but leave every voice untouched.
    load_d = (in_duration != '0) ? sel_vec : '0;
  end

  // State, chord index and the registered one-cycle load strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      idx_q   <= 2'd0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      load_q  <= load_d;
    end
  end

  assign in_ready   = rdy_c & ~reset;
  assign voice_load = load_q;
  assign note1      = note_w[0];
  assign note2      = note_w[1];
  assign note3      = note_w[2];
  assign chord_busy = (state_q == S_CHORD_WAIT) || (state_q == S_CHORD_LOAD);
  assign all_idle   = (voice_active == 3'b000);
endmodule

// File: tb/tb_chord_voice_scheduler.sv
// Directed bench for chord_voice_scheduler: expected values worked out by hand.
module tb_chord_voice_scheduler;
  logic       clk = 1'b0;
  logic       reset, play, beat, in_valid, in_chord;
  logic       in_ready, chord_busy, all_idle;
  logic [5:0] in_note, in_duration, note1, note2, note3;
  logic [2:0] voice_active, voice_load;
  int         n_assert = 0;
  int         n_fail   = 0;

  chord_voice_scheduler #(.NOTE_W(6), .DUR_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .beat         (beat),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_note      (in_note),
    .in_duration  (in_duration),
    .in_chord     (in_chord),
    .note1        (note1),
    .note2        (note2),
    .note3        (note3),
    .voice_active (voice_active),
    .voice_load   (voice_load),
    .chord_busy   (chord_busy),
    .all_idle     (all_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat = 1'b1; tick(); beat = 1'b0;
    end
  endtask

  task automatic entry(input logic [5:0] n, input logic [5:0] d);
    in_note = n; in_duration = d;
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; beat = 1'b0; in_valid = 1'b0; in_chord = 1'b0;
    in_note = '0; in_duration = '0;
    tick(); tick();
    chk("rst_load",  voice_load, 3'b000);
    chk("rst_act",   voice_active, 3'b000);
    chk("rst_note1", note1, 0);
    chk("rst_rdy",   in_ready, 0);
    chk("rst_busy",  chord_busy, 0);
    chk("rst_idle",  all_idle, 1);

    // 1: chord load into idle voices
    reset = 1'b0; play = 1'b1;
    in_valid = 1'b1; in_chord = 1'b1; entry(23, 10); #1;
    chk("t1_rdy_run", in_ready, 0);
    tick();
    chk("t1_busy_wait", chord_busy, 1);
    chk("t1_rdy_wait", in_ready, 0);
    tick();
    chk("t1_rdy_load", in_ready, 1);
    tick();
    chk("t1_load1", voice_load, 3'b001);
    chk("t1_note1", note1, 23);
    in_chord = 1'b0; entry(11, 10); tick();
    chk("t1_load2", voice_load, 3'b010);
    chk("t1_note2", note2, 11);
    entry(7, 12); tick();
    chk("t1_load3", voice_load, 3'b100);
    chk("t1_note3", note3, 7);
    chk("t1_busy_done", chord_busy, 0);
    in_valid = 1'b0;
    beats(10);
    chk("t1_act10", voice_active, 3'b100);
    chk("t1_load_clr", voice_load, 3'b000);
    beats(2);
    chk("t1_idle12", all_idle, 1);
    chk("t1_note1_off", note1, 0);

    // 2: chord waits for voice 3 (dur 2) to expire
    in_valid = 1'b1; entry(40, 2); #1;
    chk("t2_rdy_single", in_ready, 1);
    tick();
    chk("t2_load_v3", voice_load, 3'b100);
    in_chord = 1'b1; entry(50, 20); #1;
    chk("t2_rdy_chord", in_ready, 0);
    tick();
    chk("t2_busy", chord_busy, 1);
    beats(1);
    chk("t2_rdy_w1", in_ready, 0);
    beats(1);
    chk("t2_rdy_w2", in_ready, 0);
    chk("t2_act_w2", voice_active, 3'b000);
    chk("t2_busy_w2", chord_busy, 1);
    tick();
    chk("t2_rdy_load", in_ready, 1);
    tick();
    chk("t2_load1", voice_load, 3'b001);
    chk("t2_note1", note1, 50);
    in_chord = 1'b0; entry(51, 15); tick();
    chk("t2_load2", voice_load, 3'b010);
    entry(52, 10); tick();
    chk("t2_load3", voice_load, 3'b100);
    chk("t2_note3", note3, 52);
    in_valid = 1'b0;
    beats(10);
    chk("t2_act10", voice_active, 3'b011);
    beats(5);
    chk("t2_act15", voice_active, 3'b001);
    beats(5);
    chk("t2_act20", voice_active, 3'b000);

    // 3: single-note priority voice 3, 2, 1
    in_valid = 1'b1; entry(10, 40); #1;
    chk("t3_rdy", in_ready, 1);
    tick();
    chk("t3_load_a", voice_load, 3'b100);
    chk("t3_note3", note3, 10);
    entry(11, 41); tick();
    chk("t3_load_b", voice_load, 3'b010);
    chk("t3_note2", note2, 11);
    entry(12, 42); tick();
    chk("t3_load_c", voice_load, 3'b001);
    chk("t3_note1", note1, 12);
    chk("t3_act", voice_active, 3'b111);

    // 4: all voices busy; (9,4) stalls until voice 3 reaches zero
    entry(9, 4); #1;
    chk("t4_rdy_full", in_ready, 0);
    beats(39);
    chk("t4_rdy_39", in_ready, 0);
    beats(1);
    chk("t4_rdy_free", in_ready, 1);
    chk("t4_act_free", voice_active, 3'b011);
    tick();
    chk("t4_load", voice_load, 3'b100);
    chk("t4_note3", note3, 9);
    chk("t4_act", voice_active, 3'b111);
    in_valid = 1'b0;

    // 5: beat coincident with accept
    reset = 1'b1; tick(); reset = 1'b0;
    in_valid = 1'b1; entry(30, 6); tick();
    entry(31, 1); tick();
    entry(32, 6); tick();
    in_valid = 1'b0;
    chk("t5_act_setup", voice_active, 3'b111);
    beats(1);
    chk("t5_act_v2free", voice_active, 3'b101);
    beat = 1'b1; in_valid = 1'b1; entry(20, 6); #1;
    chk("t5_rdy", in_ready, 1);
    tick();
    beat = 1'b0; in_valid = 1'b0;
    chk("t5_load", voice_load, 3'b010);
    chk("t5_note2", note2, 20);
    beats(3);
    chk("t5_act3", voice_active, 3'b111);
    beats(1);
    chk("t5_act4", voice_active, 3'b010);
    beats(1);
    chk("t5_act5", voice_active, 3'b010);
    beats(1);
    chk("t5_act6", voice_active, 3'b000);

    // 6a: play=0 freezes durations and stalls input
    in_valid = 1'b1; entry(44, 3); tick();
    play = 1'b0; entry(45, 2); #1;
    chk("t6_rdy_pause", in_ready, 0);
    beats(3);
    chk("t6_rdy_pause3", in_ready, 0);
    chk("t6_act_pause", voice_active, 3'b100);
    chk("t6_note3_pause", note3, 44);
    chk("t6_load_pause", voice_load, 3'b000);
    in_valid = 1'b0; play = 1'b1;
    beats(2);
    chk("t6_act_run2", voice_active, 3'b100);
    beats(1);
    chk("t6_act_run3", voice_active, 3'b000);

    // 6b: zero-duration entry consumed without a load
    in_valid = 1'b1; entry(5, 0); #1;
    chk("t6_rdy_zero", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("t6_load_zero", voice_load, 3'b000);
    chk("t6_idle_zero", all_idle, 1);

    // 6c: reset during chord load index 1 discards the group
    in_valid = 1'b1; in_chord = 1'b1; entry(60, 5);
    tick(); tick(); tick();
    in_chord = 1'b0;
    chk("t6_load_v1", voice_load, 3'b001);
    chk("t6_busy_load", chord_busy, 1);
    reset = 1'b1; in_valid = 1'b0; #1;
    chk("t6_rdy_inrst", in_ready, 0);
    tick();
    chk("t6_rst_load", voice_load, 3'b000);
    chk("t6_rst_act", voice_active, 3'b000);
    chk("t6_rst_note1", note1, 0);
    chk("t6_rst_busy", chord_busy, 0);
    chk("t6_rst_idle", all_idle, 1);
    reset = 1'b0; #1;
    chk("t6_rdy_after", in_ready, 1);
    in_valid = 1'b1; entry(70, 3); tick();
    in_valid = 1'b0;
    chk("t6_run_alloc", voice_load, 3'b100);
    chk("t6_busy_after", chord_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
